// File: rtl/pattern_detect_ctrl_if.sv
// Config, serial stream and status bundle for pattern_detect_ctrl.
// master drives config/stream (host side); slave is the detector.
interface pattern_detect_ctrl_if #(
  parameter int unsigned CNT_W = 8
);
  logic             cfg_we;
  logic [7:0]       cfg_pattern;
  logic [3:0]       cfg_len;
  logic             cfg_overlap;
  logic [CNT_W-1:0] cfg_thresh;
  logic             start;
  logic             stop;
  logic             in_valid;
  logic             in_bit;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             irq;
  logic             busy;
  logic             cfg_err;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh,
    output start, stop, in_valid, in_bit,
    input  match, match_cnt, irq, busy, cfg_err
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_thresh,
    input  start, stop, in_valid, in_bit,
    output match, match_cnt, irq, busy, cfg_err
  );
endinterface

// File: rtl/pattern_detect_ctrl.sv
// Serial bit-pattern detector with run control, match counter, threshold irq
// and a config register that is only writable outside a run.
module pattern_detect_ctrl #(
  parameter int unsigned CNT_W = 8
) (
  input logic                  clk,
  input logic                  rst,
  pattern_detect_ctrl_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [7:0]       hist_q, hist_d;
  logic [3:0]       fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;
  logic             cfg_err_q, cfg_err_d;

  logic [7:0]       pat_q;
  logic [3:0]       len_q;
  logic             ovl_q;
  logic [CNT_W-1:0] thr_q;

  logic [7:0]       cand;
  logic [7:0]       mask;
  logic             fill_ok;
  logic             hit;
  logic             len_ok;
  logic             cfg_take;
  logic [CNT_W:0]   cnt_inc;

  always_comb begin
    cand     = {hist_q[6:0], bus.in_bit};
    // len_q is always 1..8, so the shift stays within 0..7
    mask     = 8'hFF >> (4'd8 - len_q);
    fill_ok  = ({1'b0, fill_q} + 5'd1) >= {1'b0, len_q};
    hit      = (state_q == StRun) & bus.in_valid & fill_ok &
               ((cand & mask) == (pat_q & mask)) & ~rst;
    len_ok   = (bus.cfg_len != 4'd0) && (bus.cfg_len <= 4'd8);
    cfg_take = bus.cfg_we & len_ok & (state_q != StRun);
    cfg_err_d = bus.cfg_we & ~cfg_take;
    cnt_inc  = {1'b0, cnt_q} + 1'b1;
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    irq_d   = irq_q;
    unique case (state_q)
      StRun: begin
        if (bus.stop) begin
          state_d = StIdle;
        end else if (bus.in_valid) begin
          hist_d = cand;
          fill_d = (fill_q >= 4'd8) ? 4'd8 : fill_q + 4'd1;
          if (hit) begin
            if (!ovl_q) fill_d = 4'd0;
            if (!(&cnt_q)) cnt_d = cnt_inc[CNT_W-1:0];
            if ((thr_q != '0) && (cnt_inc == {1'b0, thr_q})) begin
              state_d = StDone;
              irq_d   = 1'b1;
            end
          end
        end
      end
      default: begin
        if (bus.start) begin
          state_d = StRun;
          hist_d  = 8'h00;
          fill_d  = 4'd0;
          cnt_d   = '0;
          irq_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      hist_q    <= 8'h00;
      fill_q    <= 4'd0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      cnt_q     <= cnt_d;
      irq_q     <= irq_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= 8'h0A;
      len_q <= 4'd4;
      ovl_q <= 1'b1;
      thr_q <= '0;
    end else if (cfg_take) begin
      pat_q <= bus.cfg_pattern;
      len_q <= bus.cfg_len;
      ovl_q <= bus.cfg_overlap;
      thr_q <= bus.cfg_thresh;
    end
  end

  assign bus.match     = hit;
  assign bus.match_cnt = cnt_q;
  assign bus.irq       = irq_q;
  assign bus.busy      = (state_q == StRun);
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: doc/pattern_detect_ctrl.md
PATTERN_DETECT_CTRL -- requirements
Module: pattern_detect_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the match counter and the threshold.
REQ-002 SHALL have port clk  input  1  system clock, rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cfg_we  input  1  config write strobe.
REQ-005 SHALL have port cfg_pattern  input  8  pattern; bit [len-1] is the first bit received, bit 0 the last.
REQ-006 SHALL have port cfg_len  input  4  pattern length; legal range 1..8.
REQ-007 SHALL have port cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-008 SHALL have port cfg_thresh  input  CNT_W  match count that ends a run; 0 = never ends.
REQ-009 SHALL have port start  input  1  begin a run.
REQ-010 SHALL have port stop  input  1  abort a run.
REQ-011 SHALL have port in_valid  input  1  qualifies in_bit.
REQ-012 SHALL have port in_bit  input  1  serial data bit.
REQ-013 SHALL have port match  output  1  combinational (Mealy) pulse in the cycle the completing bit is presented.
REQ-014 SHALL have port match_cnt  output  CNT_W  registered number of matches in the current or last run.
REQ-015 SHALL have port irq  output  1  registered, sticky, threshold reached.
REQ-016 SHALL have port busy  output  1  registered, high in state RUN.
REQ-017 SHALL have port cfg_err  output  1  registered one-cycle pulse for a rejected config write.

Function
REQ-018 SHALL implement states IDLE, RUN and DONE; busy = (state == RUN).
REQ-019 SHALL latch cfg_pattern, cfg_len, cfg_overlap and cfg_thresh on cfg_we only in IDLE or DONE, and only when cfg_len is in 1..8.
REQ-020 SHALL pulse cfg_err the following cycle, with no config update, when cfg_we is asserted in RUN or cfg_len is 0 or >8.
REQ-021 SHALL go from IDLE or DONE to RUN on start, clearing hist[7:0], fill[3:0], match_cnt and irq in that transition.
REQ-022 SHALL go from RUN to IDLE on stop, retaining match_cnt; stop outside RUN SHALL be ignored.
REQ-023 SHALL give stop priority when start and stop are both asserted in RUN; in IDLE or DONE, start wins.
REQ-024 SHALL, in RUN with in_valid=1: cand = {hist[6:0], in_bit}; hist <= cand; fill <= min(fill+1, 8).
REQ-025 SHALL ignore in_bit when in_valid=0: no state change and match=0.
REQ-026 SHALL assert match = RUN & in_valid & (fill+1 >= len) & (cand[len-1:0] == pattern[len-1:0]).
REQ-027 SHALL, on a match with overlap=0, set fill <= 0 (hist don't-care); with overlap=1, fill updates per REQ-024.
REQ-028 SHALL increment match_cnt on each match, saturating at 2^CNT_W-1.
REQ-029 SHALL, when thresh != 0 and a match makes match_cnt+1 == thresh, go RUN to DONE and set irq next cycle.
REQ-030 SHALL hold irq until the next start or rst.
REQ-031 SHALL hold match at 0 in DONE and IDLE, and ignore in_valid there.
REQ-032 SHALL apply a config written in DONE to the next run only.

Reset
REQ-033 SHALL, on rst asserted at any time including mid-run, immediately force: state=IDLE, match_cnt=0, irq=0, busy=0, cfg_err=0, hist=0, fill=0.
REQ-034 SHALL reset config to pattern=8'h0A, len=4, overlap=1, thresh=0 (default detector "1010", overlapping, free-running).
REQ-035 SHALL keep match=0 while rst is high.

Verification
REQ-036 SHALL cover: default config, start, valid bits 1,0,1,0,1,0 -> match on bit 4 and bit 6, match_cnt=2, irq=0.
REQ-037 SHALL cover: overlap=0, len=4, pattern 8'h0A, bits 1,0,1,0,1,0,1,0 -> match on bits 4 and 8 only, match_cnt=2 (overlap=1 gives 3).
REQ-038 SHALL cover: thresh=2, default pattern, stream 101010 -> DONE after bit 6, irq=1, busy=0; further 1010 gives no match and match_cnt stays 2.
REQ-039 SHALL cover: cfg_we in RUN -> cfg_err pulse, pattern unchanged; cfg_we with cfg_len=0 in IDLE -> cfg_err pulse; cfg_len=9 -> cfg_err pulse.
REQ-040 SHALL cover: bits 1,0,1,0 with in_valid=0 cycles between bits -> exactly one match, on the fourth valid bit.
REQ-041 SHALL cover: rst after 3 of 4 pattern bits in RUN, then start plus a single 0 -> no match; state, counter and config back to reset values.
